pla_vector_engine: RTL and testbench



---
 rtl/pla_bench_pkg.sv | 44 ++++
 rtl/pla_vector_engine_if.sv | 28 ++
 rtl/pla_misr.sv | 35 +++
 rtl/pla_vector_engine.sv | 153 +++++++++++++++
 tb/tb_pla_vector_engine.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pla_bench_pkg.sv
// Shared types, constants and helpers for the PLA stimulus/response engine.
// The MISR step is written width-generic so any SIG_W up to MaxSigW can reuse it.
package pla_bench_pkg;

    typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

    localparam logic [15:0] DefSigPoly = 16'h8016;
    localparam int unsigned MaxSigW    = 32;

    // Maximal-length Fibonacci tap masks (bit i set = tap at bit i) for 2..16 bits.
    function automatic logic [15:0] lfsr_taps(input int unsigned n);
        case (n)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0500;
        endcase
    endfunction

    // One MISR step on the low w bits; bits above w come back as zero.
    function automatic logic [MaxSigW-1:0] misr_next(input logic [MaxSigW-1:0] sig,
                                                     input logic [MaxSigW-1:0] poly,
                                                     input logic               y,
                                                     input int unsigned        w);
        logic [MaxSigW-1:0] mask;
        logic               msb;
        mask = (32'd1 << w) - 32'd1;
        msb  = sig[w[4:0] - 5'd1];
        return (((sig << 1) ^ (msb ? poly : '0)) & mask) ^ {{(MaxSigW-1){1'b0}}, y};
    endfunction

endpackage

// File: rtl/pla_vector_engine_if.sv
// Control, stimulus and result bundle between a host and pla_vector_engine.
// master = host/logic-block side, slave = the engine itself.
interface pla_vector_engine_if #(
    parameter int unsigned N_IN  = 11,
    parameter int unsigned SIG_W = 16
);
    logic              start;
    logic              abort;
    logic              mode;
    logic [N_IN-1:0]   seed;
    logic [N_IN-1:0]   x_out;
    logic              y_in;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [N_IN:0]     onset_count;
    logic [SIG_W-1:0]  signature;

    modport master (
        output start, abort, mode, seed, y_in,
        input  x_out, busy, done, aborted, onset_count, signature
    );

    modport slave (
        input  start, abort, mode, seed, y_in,
        output x_out, busy, done, aborted, onset_count, signature
    );
endinterface

// File: rtl/pla_misr.sv
// Serial-input MISR register with synchronous clear (priority) and enable.
module pla_misr
    import pla_bench_pkg::*;
#(
    parameter int unsigned     SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DefSigPoly)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             y,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = SIG_W'(misr_next(MaxSigW'(sig_q), MaxSigW'(SIG_POLY), y, SIG_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
endmodule

// File: rtl/pla_vector_engine.sv
// Drives exhaustive-count or LFSR vectors into a PLA block and compacts its single output
// into an on-set count and a MISR signature, with a SAMPLE_LAT-deep sample-valid pipe.
module pla_vector_engine
    import pla_bench_pkg::*;
#(
    parameter int unsigned      N_IN       = 11,
    parameter int unsigned      SIG_W      = 16,
    parameter logic [SIG_W-1:0] SIG_POLY   = SIG_W'(DefSigPoly),
    parameter logic [N_IN-1:0]  LFSR_POLY  = N_IN'(lfsr_taps(N_IN)),
    parameter int unsigned      SAMPLE_LAT = 0
) (
    input logic                clk,
    input logic                rst_n,
    pla_vector_engine_if.slave bus
);
    localparam int unsigned    PipeW   = (SAMPLE_LAT > 0) ? SAMPLE_LAT : 1;
    localparam logic [N_IN-1:0] AllOnes = '1;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   x_q, x_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic              mode_q, mode_d;
    logic [PipeW-1:0]  pipe_q, pipe_d;
    logic [N_IN:0]     onset_q, onset_d;
    logic              aborted_q, aborted_d;
    logic              clr, run, last, tap, sample;
    logic [SIG_W-1:0]  sig;

    assign run  = (state_q == StDrive) || (state_q == StDrain);
    // Mode 1 presents one vector fewer because the all-zero state is unreachable.
    assign last = mode_q ? (idx_q == AllOnes - 1'b1) : (idx_q == AllOnes);

    if (SAMPLE_LAT == 0) begin : g_lat0
        assign tap = (state_q == StDrive);
    end else begin : g_latn
        assign tap = pipe_q[PipeW-1];
    end

    // The abort edge takes no sample: partial results freeze as they were.
    assign sample = run && tap && !bus.abort;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        pipe_d    = pipe_q;
        aborted_d = aborted_q;
        clr       = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StDrive;
                    mode_d    = bus.mode;
                    idx_d     = '0;
                    pipe_d    = '0;
                    aborted_d = 1'b0;
                    clr       = 1'b1;
                    if (!bus.mode) begin
                        x_d = '0;
                    end else if (bus.seed == '0) begin
                        x_d = N_IN'(1);
                    end else begin
                        x_d = bus.seed;
                    end
                end
            end
            StDrive: begin
                if (bus.abort) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else begin
                    pipe_d = (pipe_q << 1) | PipeW'(1);
                    if (last) begin
                        if (SAMPLE_LAT == 0) begin
                            state_d = StDone;
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (mode_q) begin
                            x_d = {x_q[N_IN-2:0], ^(x_q & LFSR_POLY)};
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            StDrain: begin
                if (bus.abort) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else begin
                    pipe_d = pipe_q << 1;
                    if (pipe_d == '0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        onset_d = onset_q;
        if (clr) begin
            onset_d = '0;
        end else if (sample && bus.y_in) begin
            onset_d = onset_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            x_q       <= '0;
            idx_q     <= '0;
            mode_q    <= 1'b0;
            pipe_q    <= '0;
            onset_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            pipe_q    <= pipe_d;
            onset_q   <= onset_d;
            aborted_q <= aborted_d;
        end
    end

    pla_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (sample),
        .y     (bus.y_in),
        .sig   (sig)
    );

    assign bus.x_out       = x_q;
    assign bus.busy        = run;
    assign bus.done        = (state_q == StDone);
    assign bus.aborted     = aborted_q;
    assign bus.onset_count = onset_q;
    assign bus.signature   = sig;
endmodule

// File: tb/tb_pla_vector_engine.sv
// Bench for pla_vector_engine: a SAMPLE_LAT=0 and a SAMPLE_LAT=2 instance run side by side
// on shared controls; the LAT=2 block output is delayed two cycles by the bench.
module tb_pla_vector_engine;
    logic        clk;
    logic        rst_n;
    logic        start, abort, mode;
    logic [10:0] seed;
    int          ysel;
    logic        tt [2048];
    logic [10:0] xd1, xd2;
    logic        y0, y2;
    int          n_tests, n_fail;

    pla_vector_engine_if #(.N_IN(11), .SIG_W(16)) if0 ();
    pla_vector_engine_if #(.N_IN(11), .SIG_W(16)) if2 ();

    pla_vector_engine #(.N_IN(11), .SIG_W(16), .SAMPLE_LAT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    pla_vector_engine #(.N_IN(11), .SIG_W(16), .SAMPLE_LAT(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign if0.start = start;
    assign if0.abort = abort;
    assign if0.mode  = mode;
    assign if0.seed  = seed;
    assign if2.start = start;
    assign if2.abort = abort;
    assign if2.mode  = mode;
    assign if2.seed  = seed;

    // Function of the logic block under test: 0, x[0], 1 or a random truth table.
    function automatic logic yof(input int ys, input logic [10:0] x);
        case (ys)
            0:       return 1'b0;
            1:       return x[0];
            2:       return 1'b1;
            default: return tt[x];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        xd1 <= if2.x_out;
        xd2 <= xd1;
    end

    always_comb begin
        y0 = yof(ysel, if0.x_out);
        y2 = yof(ysel, xd2);
    end
    assign if0.y_in = y0;
    assign if2.y_in = y2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk the first n vectors of the run and fold each response in.
    function automatic void model(input bit m, input logic [10:0] sd, input int ys,
                                  input int n, output int on, output logic [15:0] sg,
                                  output logic [10:0] lastx);
        logic [10:0] x;
        logic        y;
        x     = m ? ((sd == 11'd0) ? 11'd1 : sd) : 11'd0;
        on    = 0;
        sg    = 16'h0000;
        lastx = x;
        for (int i = 0; i < n; i++) begin
            y = yof(ys, x);
            if (y) on++;
            sg    = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h8016 : 16'h0000) ^ {15'd0, y};
            lastx = x;
            x     = m ? {x[9:0], ^(x & 11'h500)} : x + 11'd1;
        end
    endfunction

    task automatic run_case(input bit m, input logic [10:0] sd, input int ys, input int ab,
                            input int exp_on0);
        int          total, n0, n2, on0, on2, dc0, dc2, cyc, distinct, ndup;
        logic [15:0] sg0, sg2;
        logic [10:0] lx0, lx2, first;
        bit          got0, got2;
        bit          seen [2048];
        total = m ? 2047 : 2048;
        n0    = (ab > 0) ? ab - 1 : total;
        n2    = (ab > 3) ? ab - 3 : ((ab > 0) ? 0 : total);
        model(m, sd, ys, n0, on0, sg0, lx0);
        model(m, sd, ys, n2, on2, sg2, lx2);
        if (exp_on0 >= 0) on0 = exp_on0;
        dc0   = (ab > 0) ? ab + 1 : total + 1;
        dc2   = (ab > 0) ? ab + 1 : total + 3;
        first = m ? ((sd == 11'd0) ? 11'd1 : sd) : 11'd0;
        for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
        got0 = 1'b0; got2 = 1'b0; distinct = 0; ndup = 0;
        ysel = ys;
        @(negedge clk);
        start = 1'b1; mode = m; seed = sd;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        check("busy_at_start", if0.busy, 1);
        check("first_x", if0.x_out, first);
        check("aborted_cleared", if0.aborted, 0);
        while (!(got0 && got2)) begin
            if (cyc > total + 20) begin
                n_tests++; n_fail++;
                $display("FAIL run_timeout: done0=%0d done2=%0d after %0d cycles, required both",
                         got0, got2, cyc);
                break;
            end
            start = (cyc == 10);  // start while busy must be ignored
            if (ab > 0 && cyc == ab) abort = 1'b1;
            if (if0.busy) begin
                if (seen[if0.x_out]) ndup++;
                else begin seen[if0.x_out] = 1'b1; distinct++; end
            end
            if (if0.done && !got0) begin
                got0 = 1'b1;
                check("done_cycle_lat0", cyc, dc0);
                check("onset_lat0", if0.onset_count, on0);
                check("sig_lat0", if0.signature, sg0);
                check("aborted_lat0", if0.aborted, ab > 0);
                if (ab == 0) check("last_x_lat0", if0.x_out, lx0);
            end
            if (if2.done && !got2) begin
                got2 = 1'b1;
                check("done_cycle_lat2", cyc, dc2);
                check("onset_lat2", if2.onset_count, on2);
                check("sig_lat2", if2.signature, sg2);
                check("aborted_lat2", if2.aborted, ab > 0);
                if (ab == 0) check("last_x_lat2", if2.x_out, lx2);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
        check("done_one_shot", {if0.done, if2.done}, 0);
        check("idle_after_done", {if0.busy, if2.busy}, 0);
        if (m && ab == 0) begin
            check("lfsr_distinct", distinct, 2047);
            check("lfsr_repeats", ndup, 0);
            check("lfsr_no_zero", seen[0], 0);
        end
    endtask

    typedef struct {
        bit          mode;
        logic [10:0] seed;
        int          ysel;
        int          abort_at;
        int          exp_onset0;  // -1: take from the reference model
    } vec_t;

    vec_t vecs [8];

    initial begin
        int nd;
        n_tests = 0; n_fail = 0;
        start = 1'b0; abort = 1'b0; mode = 1'b0; seed = '0; ysel = 0;
        for (int i = 0; i < 2048; i++) tt[i] = 1'($urandom_range(0, 1));

        vecs[0] = '{1'b0, 11'd0,    0, 0,   0};
        vecs[1] = '{1'b0, 11'd0,    1, 0,   1024};
        vecs[2] = '{1'b0, 11'd0,    2, 0,   2048};
        vecs[3] = '{1'b1, 11'd0,    2, 0,   2047};
        vecs[4] = '{1'b0, 11'd0,    2, 100, 99};
        vecs[5] = '{1'b1, 11'h2A7,  3, 0,   -1};
        vecs[6] = '{1'b0, 11'd0,    3, 0,   -1};
        vecs[7] = '{1'b1, 11'h5A5,  1, 37,  -1};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_x_out", if0.x_out, 0);
        check("rst_busy", if0.busy, 0);
        check("rst_done", if0.done, 0);
        check("rst_aborted", if0.aborted, 0);
        check("rst_onset", if0.onset_count, 0);
        check("rst_sig", {if0.signature, if2.signature}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_case(vecs[v].mode, vecs[v].seed, vecs[v].ysel, vecs[v].abort_at,
                     vecs[v].exp_onset0);
        end

        // Reset pulse in the middle of a run.
        ysel = 2;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; seed = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        check("pre_reset_busy", if0.busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_x_out", {if0.x_out, if2.x_out}, 0);
        check("midrst_busy", {if0.busy, if2.busy}, 0);
        check("midrst_onset", {if0.onset_count, if2.onset_count}, 0);
        check("midrst_sig", {if0.signature, if2.signature}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (if0.done || if2.done || if0.busy) nd++;
        end
        check("no_done_after_reset", nd, 0);
        run_case(1'b0, 11'd0, 3, 0, -1);

        for (int r = 0; r < 4; r++) begin
            bit          rm;
            logic [10:0] rs;
            int          ry, ra;
            for (int i = 0; i < 2048; i++) tt[i] = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            rs = 11'($urandom);
            ry = int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 1800)) : 0;
            run_case(rm, rs, ry, ra, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
